// File: rtl/multiplicacion_booth.sv
// Sequential signed multiplier, radix-2 Booth recoding, one iteration per clock.
// Operands are captured in IDLE; the 2*WIDTH-bit product appears with a one-cycle done pulse.
module multiplicacion_booth #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Mult,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;

  // One Booth step: add/subtract by the recoded pair, then arithmetic shift of {acc,q,q_1}.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_1})
      2'b10:   acc_sum = acc - m;
      2'b01:   acc_sum = acc + m;
      default: acc_sum = acc;
    endcase
    acc_sh = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    q_sh   = {acc_sum[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      Mult  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            // Extra sign bit keeps -2^(WIDTH-1) exact when negated.
            m     <= {A[WIDTH-1], A};
            q     <= B;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= CNT_INIT;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            Mult  <= {acc_sh[WIDTH-1:0], q_sh};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicacion_booth.sv
// Bench for multiplicacion_booth: directed and random operands checked against
// a plain signed-arithmetic reference, plus back-to-back, async reset and abort cases.
module tb_multiplicacion_booth;

  localparam int W = 8;
  localparam int TIMEOUT = 4 * W;

  logic           clk;
  logic           rst;
  logic           valid;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] mult;
  logic           done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*W-1:0] exp_q[$];

  multiplicacion_booth #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .A     (a),
    .B     (b),
    .Mult  (mult),
    .done  (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference: full signed product truncated to the 2W-bit result width
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_operand();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 8'h80;
    if (sel == 1) return 8'h7F;
    if (sel == 2) return 8'h00;
    return W'($urandom);
  endfunction

  // driver: one operation, operands scrambled after capture, bounded wait for done
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [2*W-1:0] exp;
    bit seen;
    @(negedge clk);
    a = x;
    b = y;
    valid = 1'b1;
    exp_q.push_back(ref_mult(x, y));
    @(negedge clk);
    valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    exp = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_mult"}, 32'(mult), 32'(exp));
      @(negedge clk);
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_mult_hold"}, 32'(mult), 32'(exp));
    end
  endtask

  // valid held high, operands changing every cycle: only captured operands matter
  task automatic back_to_back();
    logic [W-1:0]   av[0:29];
    logic [W-1:0]   bv[0:29];
    int             d_idx[$];
    logic [2*W-1:0] d_val[$];
    for (int e = 0; e < 30; e++) begin
      av[e] = rand_operand();
      bv[e] = rand_operand();
    end
    for (int e = 0; e < 46; e++) begin
      @(negedge clk);
      if (done) begin
        d_idx.push_back(e);
        d_val.push_back(mult);
      end
      if (e < 30) begin
        a = av[e];
        b = bv[e];
        valid = 1'b1;
      end else begin
        a = W'($urandom);
        b = W'($urandom);
        valid = 1'b0;
      end
    end
    check("b2b_done_count", 32'(d_idx.size()), 32'd3);
    if (d_idx.size() == 3) begin
      check("b2b_spacing_1", 32'(d_idx[1] - d_idx[0]), 32'd10);
      check("b2b_spacing_2", 32'(d_idx[2] - d_idx[1]), 32'd10);
      for (int k = 0; k < 3; k++)
        check($sformatf("b2b_mult_%0d", k), 32'(d_val[k]), 32'(ref_mult(av[10*k], bv[10*k])));
    end
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1;
    valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_mult", 32'(mult), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    do_op(8'd4, 8'd7, "d_4x7");
    do_op(8'hFD, 8'd5, "d_m3x5");
    do_op(8'd0, 8'hB3, "d_0xm77");
    do_op(8'h80, 8'h80, "d_m128xm128");
    do_op(8'h7F, 8'h80, "d_127xm128");
    do_op(8'h80, 8'd1, "d_m128x1");

    for (int i = 0; i < 40; i++)
      do_op(rand_operand(), rand_operand(), $sformatf("rnd_%0d", i));

    back_to_back();

    // async reset mid-cycle during CALC
    do_op(8'd9, 8'd11, "pre_abort");
    @(negedge clk);
    a = 8'd100;
    b = 8'd3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mult", 32'(mult), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_mult_zero", 32'(mult), 32'd0);
    do_op(8'd6, 8'hFE, "post_abort_6xm2");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
